// File: rtl/tablet_pkg.sv
// -----------------------------------------------------------------------------
// tablet_pkg
// Shared definitions for the tablet-bottling drive side and its neighbours
// (setter / compare logic). The tablets-per-bottle limit lives here only.
//   CNT_W        : width of tablet and bottle counts / settings
//   MAX_TAB      : largest legal tablets-per-bottle setting
//   feed_state_t : sequencer states of tablet_feeder
// -----------------------------------------------------------------------------
package tablet_pkg;

    localparam int CNT_W   = 7;
    localparam int MAX_TAB = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BOT,
        ST_DROP,
        ST_GAP,
        ST_ADVANCE,
        ST_DONE,
        ST_ERR
    } feed_state_t;

endpackage

// File: rtl/strobe_timer.sv
// -----------------------------------------------------------------------------
// strobe_timer
// Loadable down-counter used to time strobe high and low phases. Loading N-1
// makes o_last rise after N cycles in the phase; once at zero the counter
// holds there, so a phase may be extended with o_last staying high.
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   i_load     : load i_load_val (phase entry)
//   i_load_val : phase length minus one
//   o_last     : current cycle is the last (or a held-over) cycle of the phase
// -----------------------------------------------------------------------------
module strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/tablet_feeder.sv
// -----------------------------------------------------------------------------
// tablet_feeder
// Drive side of the tablet-bottling pulse interface. Runs one bottle at a
// time: wait for a bottle, drop set_tab tablets, advance the conveyor, repeat
// until set_bot bottles are filled. All outputs are registered.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : run enable level; rising edge starts, low aborts
//   pause             : freeze request, honoured in WAIT_BOT and after a gap
//   set_tab, set_bot  : tablets per bottle / bottles per run, sampled on start
//   bot_ready         : bottle-in-place sensor
//   drop, advance     : tablet strobe / conveyor advance strobe
//   tab_cnt, bot_cnt  : tablets in current bottle / bottles completed
//   busy, done, err   : run in progress / run complete / fault
// -----------------------------------------------------------------------------
module tablet_feeder
    import tablet_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 4,
    parameter int ADV_W   = 8,
    parameter int MAX_TAB = tablet_pkg::MAX_TAB
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] set_tab,
    input  logic [CNT_W-1:0] set_bot,
    input  logic             bot_ready,
    output logic             drop,
    output logic             advance,
    output logic [CNT_W-1:0] tab_cnt,
    output logic [CNT_W-1:0] bot_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? ((PULSE_W > ADV_W) ? PULSE_W : ADV_W)
                                             : ((GAP_W > ADV_W) ? GAP_W : ADV_W);
    localparam int TMR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    feed_state_t      r_state;
    feed_state_t      w_state_next;
    logic             r_start_prev;
    logic [CNT_W-1:0] r_set_tab;
    logic [CNT_W-1:0] r_set_bot;
    logic [CNT_W-1:0] r_tab_cnt;
    logic [CNT_W-1:0] r_bot_cnt;
    logic             r_drop;
    logic             r_advance;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_run_start;
    logic             w_tab_inc;
    logic             w_bottle_done;
    logic             w_bad_set;
    logic [CNT_W-1:0] w_bot_cnt_inc;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_last;

    assign w_bad_set     = (set_tab == '0) || (set_tab > CNT_W'(MAX_TAB)) || (set_bot == '0);
    assign w_bot_cnt_inc = r_bot_cnt + 1'b1;

    // One timer serves every timed phase: it is reloaded on each state change.
    strobe_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_last     (w_tmr_last)
    );

    // Next-state logic. Abort beats a missing bottle, which beats pause.
    always_comb begin
        w_state_next  = r_state;
        w_run_start   = 1'b0;
        w_tab_inc     = 1'b0;
        w_bottle_done = 1'b0;
        if (r_state != ST_IDLE && !start) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !r_start_prev) begin
                        w_run_start  = 1'b1;
                        w_state_next = w_bad_set ? ST_ERR : ST_WAIT_BOT;
                    end
                end
                ST_WAIT_BOT: begin
                    if (bot_ready && !pause) begin
                        w_state_next = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!bot_ready) begin
                        w_state_next = ST_ERR;
                    end else if (w_tmr_last) begin
                        w_tab_inc    = 1'b1;
                        w_state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Timer saturates at zero, so a paused gap keeps w_tmr_last high.
                    if (!bot_ready) begin
                        w_state_next = ST_ERR;
                    end else if (w_tmr_last) begin
                        if (r_tab_cnt == r_set_tab) begin
                            w_state_next = ST_ADVANCE;
                        end else if (!pause) begin
                            w_state_next = ST_DROP;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (w_tmr_last) begin
                        w_bottle_done = 1'b1;
                        w_state_next  = (w_bot_cnt_inc == r_set_bot) ? ST_DONE : ST_WAIT_BOT;
                    end
                end
                ST_DONE: w_state_next = ST_DONE;
                ST_ERR:  w_state_next = ST_ERR;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Timer reload value for the phase being entered.
    always_comb begin
        w_tmr_load = (w_state_next != r_state);
        w_tmr_val  = '0;
        case (w_state_next)
            ST_DROP:    w_tmr_val = TMR_W'(PULSE_W - 1);
            ST_GAP:     w_tmr_val = TMR_W'(GAP_W - 1);
            ST_ADVANCE: w_tmr_val = TMR_W'(ADV_W - 1);
            default:    w_tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_start_prev resets high so a start level held through reset is not
    // mistaken for a rising edge once reset releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_prev <= 1'b1;
        end else begin
            r_start_prev <= start;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_set_tab <= '0;
            r_set_bot <= '0;
            r_tab_cnt <= '0;
            r_bot_cnt <= '0;
        end else if (w_run_start) begin
            r_set_tab <= set_tab;
            r_set_bot <= set_bot;
            r_tab_cnt <= '0;
            r_bot_cnt <= '0;
        end else if (w_tab_inc) begin
            r_tab_cnt <= r_tab_cnt + 1'b1;
        end else if (w_bottle_done) begin
            r_tab_cnt <= '0;
            r_bot_cnt <= w_bot_cnt_inc;
        end
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop    <= 1'b0;
            r_advance <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_drop    <= (w_state_next == ST_DROP);
            r_advance <= (w_state_next == ST_ADVANCE);
            r_busy    <= (w_state_next == ST_WAIT_BOT) || (w_state_next == ST_DROP) ||
                         (w_state_next == ST_GAP)      || (w_state_next == ST_ADVANCE);
            r_done    <= (w_state_next == ST_DONE);
            r_err     <= (w_state_next == ST_ERR);
        end
    end

    assign drop    = r_drop;
    assign advance = r_advance;
    assign tab_cnt = r_tab_cnt;
    assign bot_cnt = r_bot_cnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_tablet_feeder.sv
// -----------------------------------------------------------------------------
// tb_tablet_feeder
// Drives runs of tablet_feeder with per-cycle pause / bot_ready vectors and
// compares every output against an expected timeline built by walking the
// bottles and tablets of the run with plain loops.
// -----------------------------------------------------------------------------
module tb_tablet_feeder;

    localparam int PW   = 2;
    localparam int GW   = 4;
    localparam int AW   = 8;
    localparam int MT   = 50;
    localparam int NMAX = 2100;

    localparam int K_WAIT = 0;
    localparam int K_DROP = 1;
    localparam int K_GAP  = 2;
    localparam int K_ADV  = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    typedef struct {
        bit d;
        bit a;
        bit bz;
        bit dn;
        bit er;
        int tc;
        int bc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic [6:0] set_tab;
    logic [6:0] set_bot;
    logic       bot_ready;
    logic       drop;
    logic       advance;
    logic [6:0] tab_cnt;
    logic [6:0] bot_cnt;
    logic       busy;
    logic       done;
    logic       err;

    exp_t ex [NMAX];
    bit   pv [NMAX];
    bit   bv [NMAX];

    int n_total = 0;
    int n_bad   = 0;
    int cur_cyc = -1;

    tablet_feeder #(
        .PULSE_W (PW),
        .GAP_W   (GW),
        .ADV_W   (AW),
        .MAX_TAB (MT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pause     (pause),
        .set_tab   (set_tab),
        .set_bot   (set_bot),
        .bot_ready (bot_ready),
        .drop      (drop),
        .advance   (advance),
        .tab_cnt   (tab_cnt),
        .bot_cnt   (bot_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input integer got, input integer want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cur_cyc, got, want);
        end
    endtask

    task automatic check_state(input bit d, input bit a, input bit bz, input bit dn,
                               input bit er, input int tc, input int bc);
        chk("drop",    drop,    d);
        chk("advance", advance, a);
        chk("busy",    busy,    bz);
        chk("done",    done,    dn);
        chk("err",     err,     er);
        chk("tab_cnt", tab_cnt, tc);
        chk("bot_cnt", bot_cnt, bc);
    endtask

    function automatic void put(input int c, input int kind, input int tc, input int bc);
        if (c < NMAX) begin
            ex[c].d  = (kind == K_DROP);
            ex[c].a  = (kind == K_ADV);
            ex[c].bz = (kind == K_WAIT) || (kind == K_DROP) || (kind == K_GAP) || (kind == K_ADV);
            ex[c].dn = (kind == K_DONE);
            ex[c].er = (kind == K_ERR);
            ex[c].tc = tc;
            ex[c].bc = bc;
        end
    endfunction

    // Cycle 0 is the first cycle after the start-rise edge. pv[c]/bv[c] are
    // the pause / bot_ready levels applied during cycle c.
    task automatic build(input int T, input int B, input int ab, output int len);
        int c;
        bit fail;
        int hold_tc;
        int hold_bc;
        c = 0; fail = 1'b0; hold_tc = 0; hold_bc = 0;
        if (T == 0 || T > MT || B == 0) begin
            fail = 1'b1;
        end else begin
            for (int b = 0; b < B && !fail; b++) begin
                // wait for a bottle and no pause
                while (c < NMAX) begin
                    put(c, K_WAIT, 0, b);
                    c++;
                    if (bv[c-1] && !pv[c-1]) break;
                end
                for (int t = 0; t < T && !fail; t++) begin
                    for (int k = 0; k < PW + GW && !fail; k++) begin
                        int tcv;
                        tcv = (k < PW) ? t : t + 1;
                        put(c, (k < PW) ? K_DROP : K_GAP, tcv, b);
                        if (!bv[c]) begin fail = 1'b1; hold_tc = tcv; hold_bc = b; end
                        c++;
                    end
                    // a pause seen at the end of an inner gap stretches it
                    while (!fail && t < T - 1 && c < NMAX && pv[c-1]) begin
                        put(c, K_GAP, t + 1, b);
                        if (!bv[c]) begin fail = 1'b1; hold_tc = t + 1; hold_bc = b; end
                        c++;
                    end
                end
                if (!fail) begin
                    for (int k = 0; k < AW; k++) begin
                        put(c, K_ADV, T, b);
                        c++;
                    end
                end
            end
        end
        len = c + 3;
        if (len > NMAX - 1) len = NMAX - 1;
        for (int i = c; i < NMAX; i++) begin
            put(i, fail ? K_ERR : K_DONE, fail ? hold_tc : 0, fail ? hold_bc : B);
        end
        // abort: idle from the next cycle with counts frozen
        if (ab >= 0 && ab < NMAX) begin
            for (int i = ab + 1; i < NMAX; i++) begin
                ex[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex[ab].tc, ex[ab].bc};
            end
        end
    endtask

    task automatic run_case(input int T, input int B, input int pct,
                            input int plo, input int phi, input int blo, input int bhi,
                            input int ab);
        int len;
        for (int i = 0; i < NMAX; i++) begin
            pv[i] = ($urandom_range(0, 99) < pct) || (i >= plo && i < phi);
            bv[i] = !(i >= blo && i < bhi);
        end
        build(T, B, ab, len);
        $display("run set_tab=%0d set_bot=%0d pause_pct=%0d bot_low=[%0d,%0d) abort=%0d cycles=%0d",
                 T, B, pct, blo, bhi, ab, len);
        set_tab   = 7'(T);
        set_bot   = 7'(B);
        start     = 1'b1;
        pause     = 1'b0;
        bot_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < len; c++) begin
            cur_cyc = c;
            check_state(ex[c].d, ex[c].a, ex[c].bz, ex[c].dn, ex[c].er, ex[c].tc, ex[c].bc);
            pause     = pv[c];
            bot_ready = bv[c];
            start     = (ab < 0 || c < ab);
            set_tab   = 7'($urandom);
            set_bot   = 7'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        pause = 1'b0;
        bot_ready = 1'b1;
        @(posedge clk); #1;
        cur_cyc = len + 1;
        check_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex[len].tc, ex[len].bc);
    endtask

    initial begin
        int T, B, pct, blo, bhi, ab;
        reset_n = 1'b0; start = 1'b0; pause = 1'b0;
        set_tab = '0; set_bot = '0; bot_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // basic run
        run_case(3, 2, 0, -1, -1, -1, -1, -1);
        // illegal settings
        run_case(51, 1, 0, -1, -1, -1, -1, -1);
        run_case(0, 2, 0, -1, -1, -1, -1, -1);
        run_case(3, 0, 0, -1, -1, -1, -1, -1);
        // boundaries
        run_case(50, 1, 0, -1, -1, -1, -1, -1);
        run_case(1, 127, 0, -1, -1, -1, -1, -1);
        // pause from the first cycle of drop 2
        run_case(3, 1, 0, 7, 15, -1, -1, -1);
        // bottle missing at start, then missing during a gap
        run_case(2, 1, 0, -1, -1, 0, 5, -1);
        run_case(3, 1, 0, -1, -1, 3, 4, -1);
        // abort during advance, then restart
        run_case(3, 2, 0, -1, -1, -1, -1, 21);
        run_case(3, 2, 0, -1, -1, -1, -1, -1);

        // async reset mid-drop with start held high
        set_tab = 7'd3; set_bot = 7'd2; start = 1'b1; pause = 1'b0; bot_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cur_cyc = 1;
        chk("pre_reset_drop", drop, 1);
        #2 reset_n = 1'b0;
        #1;
        check_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cur_cyc = i;
            chk("post_reset_drop", drop, 0);
            chk("post_reset_busy", busy, 0);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            T   = $urandom_range(1, 6);
            B   = $urandom_range(1, 4);
            pct = $urandom_range(0, 40);
            blo = -1; bhi = -1; ab = -1;
            if ($urandom_range(0, 2) == 0) begin
                blo = $urandom_range(0, 60);
                bhi = blo + $urandom_range(1, 3);
            end
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 40);
            run_case(T, B, pct, -1, -1, blo, bhi, ab);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
